// File: rtl/data_bus_responder.sv
// Data-side bus responder for the single-cycle RV32 core: word RAM plus an MMIO window
// holding an LED register, a free-running cycle counter and a byte TX FIFO.
module data_bus_responder #(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic [7:0]  led,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        addrError
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [31:0] ADDR_LED    = 32'h8000_0000;
    localparam logic [31:0] ADDR_CNT    = 32'h8000_0004;
    localparam logic [31:0] ADDR_TXDATA = 32'h8000_0008;
    localparam logic [31:0] ADDR_TXSTAT = 32'h8000_000C;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_fifo [TX_DEPTH];
    logic [7:0]    r_led;
    logic [31:0]   r_cnt;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_addr_err;

    logic          w_sel_ram;
    logic          w_sel_led;
    logic          w_sel_cnt;
    logic          w_sel_txd;
    logic          w_sel_txs;
    logic          w_bad;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_push_full;
    logic [AW-1:0] w_ram_idx;

    // Address decode; the MMIO compares are exact so misalignment falls out as a miss.
    assign w_sel_ram = (dataAddr[31:AW+2] == '0) && (dataAddr[1:0] == 2'b00);
    assign w_sel_led = (dataAddr == ADDR_LED);
    assign w_sel_cnt = (dataAddr == ADDR_CNT);
    assign w_sel_txd = (dataAddr == ADDR_TXDATA);
    assign w_sel_txs = (dataAddr == ADDR_TXSTAT);
    assign w_bad     = !(w_sel_ram || w_sel_led || w_sel_cnt || w_sel_txd || w_sel_txs);
    assign w_ram_idx = dataAddr[AW+1:2];

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(TX_DEPTH));
    assign w_push      = we && w_sel_txd && !w_full;
    assign w_push_full = we && w_sel_txd && w_full;
    assign w_pop       = !w_empty && txReady;

    assign led       = r_led;
    assign addrError = r_addr_err;
    assign txValid   = !w_empty;
    assign txData    = w_empty ? 8'h00 : r_fifo[r_head];

    // Zero-latency read mux so a load completes in the same cycle.
    always_comb begin
        readData = 32'h0;
        if (w_sel_ram) begin
            readData = r_ram[w_ram_idx];
        end else if (w_sel_led) begin
            readData = {24'h0, r_led};
        end else if (w_sel_cnt) begin
            readData = r_cnt;
        end else if (w_sel_txs) begin
            readData = {16'h0, 8'(r_count), 5'b0, r_ovf, w_empty, w_full};
        end
    end

    // Storage arrays carry no reset; RAM survives reset and stale FIFO slots are never read.
    always_ff @(posedge clk) begin
        if (we && w_sel_ram) begin
            r_ram[w_ram_idx] <= writeData;
        end
        if (w_push) begin
            r_fifo[r_tail] <= writeData[7:0];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_led      <= 8'h00;
            r_cnt      <= 32'h0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= we && w_bad;
            if (we && w_sel_led) begin
                r_led <= writeData[7:0];
            end
            if (we && w_sel_cnt) begin
                r_cnt <= writeData;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Fullness is judged before the same-cycle pop, so a push into a full FIFO is always dropped.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (we && w_sel_txs) begin
                r_ovf <= 1'b0;
            end else if (w_push_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Data-side responder for the single-cycle RV32 `cpu` data port (`dataAddr`/`writeData`/`we` in, `readData` out).
- Provides word-addressed data RAM plus a small memory-mapped I/O window: LED register, free-running cycle counter, and a byte TX FIFO with a valid/ready drain port toward a future UART transmitter.
- Reads are same-cycle, because the CPU completes a `lw` in one cycle. All writes and state updates occur on the rising clock edge.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words; power of two, at least 4.
- TX_DEPTH, 4, TX FIFO depth in bytes; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- dataAddr  in  32  byte address from CPU.
- writeData  in  32  store data from CPU.
- we  in  1  write enable from CPU; a write occurs only when `we` is 1 at the clock edge.
- readData  out  32  load data to CPU; combinational.
- led  out  8  LED register.
- txData  out  8  FIFO head byte.
- txValid  out  1  FIFO not empty.
- txReady  in  1  consumer accepts `txData` this cycle.
- addrError  out  1  registered one-cycle pulse on a bad access.

Behaviour:
- Interface: one clock `clk`. Reset `n_reset` is asynchronous and active-low.

- Reset values:
  - `led` = 0, counter = 0, FIFO empty, `txValid` = 0, `txData` = 0.
  - Overflow flag = 0, `addrError` = 0.
  - RAM contents are NOT cleared.
  - `readData` during reset follows the decode below; RAM reads return whatever the RAM holds.

- Address map (`dataAddr[1:0]` must be 00; word access only):
  - 0x0000_0000 .. RAM_WORDS*4-1: RAM, read/write, index `dataAddr[log2(RAM_WORDS)+1:2]`.
  - 0x8000_0000: LED. Read returns {24'b0, led}. Write sets `led` = `writeData[7:0]`.
  - 0x8000_0004: COUNTER. Read returns the current count. Write loads `writeData`.
  - 0x8000_0008: TXDATA. Write pushes `writeData[7:0]`. Read returns 0.
  - 0x8000_000C: TXSTAT. Read returns {count field at bits [15:8], 5'b0, overflow at bit 2, empty at bit 1, full at bit 0}. Any write clears overflow.
  - Anything else, or a misaligned address, is a bad access.

- Bad access:
  - `readData` = 0, and any write is ignored.
  - `addrError` = 1 in the following cycle, but only if `we` = 1. Unmapped reads are not flagged.
  - `addrError` is a single-cycle pulse; back-to-back bad writes hold it high.

- Read path: combinational from `dataAddr`, with zero latency. A RAM word written at edge N is visible on `readData` right after edge N.

- Counter:
  - Increments by 1 every cycle out of reset; wraps from 0xFFFF_FFFF to 0.
  - A write at edge N makes the counter equal `writeData` after edge N, then it increments from there.
  - The write has priority over the increment.

- TX FIFO:
  - Circular buffer with pointer width log2(TX_DEPTH) and count width log2(TX_DEPTH)+1.
  - Push occurs when `we` = 1, the address is TXDATA, and the FIFO is not full. Fullness is evaluated before any same-cycle pop.
  - A push attempted while full is dropped and sets sticky overflow, even if a pop happens in the same cycle.
  - Pop occurs when `txValid` and `txReady` are both 1.
  - `txValid` = !empty. `txData` = head entry, combinational from storage; it is 0 when empty.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - Pointers wrap modulo TX_DEPTH.
  - Overflow is cleared only by reset or a TXSTAT write. If a TXSTAT write and an overflowing push fall in the same cycle, clear wins; that is impossible anyway with a single port.

- Reset mid-operation: all registered state returns to its reset value immediately (asynchronously); in-flight FIFO contents are discarded.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> `readData` = 0xDEADBEEF in the same cycle the address is presented; 0x0000_0014 is not affected.
2. Write 0x1A5 to 0x8000_0000 -> `led` = 0xA5 after the edge; reading 0x8000_0000 returns 0x0000_00A5.
3. Write 0xFFFF_FFFE to COUNTER -> reads give 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on three consecutive cycles.
4. With `txReady` = 0, push 0x11, 0x22, 0x33, 0x44, 0x55 -> TXSTAT = 0x0000_0405 (count 4, overflow, full). Then `txReady` = 1 -> `txData` reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `txValid` drops after the 4th, and 0x55 never appears.
5. With FIFO holding 1 entry, push and pop in the same cycle -> count stays 1, and the new head is the pushed byte.
6. Write to 0x0000_0002 and to 0x4000_0000 -> RAM unchanged, `addrError` high for one cycle after each write, and `readData` = 0 for both addresses. Assert `n_reset` low with the FIFO non-empty -> `txValid` = 0 and `led` = 0 immediately, without waiting for a clock edge.
